serial_async_tx: RTL and testbench



---
 rtl/serial_async_tx.sv | 156 +++++++++++++++
 tb/tb_serial_async_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_async_tx.sv
// rtl/serial_async_tx.sv - UART-style serial transmitter with internal baud clock-enable divider
module serial_async_tx #(
    parameter int   MAIN_CLK_HZ   = 50_000_000,
    parameter int   SERIAL_CLK_HZ = 9_600,
    parameter logic SERIAL_START  = 1'b0,
    parameter logic SERIAL_STOP   = 1'b1,
    parameter int   BITS          = 8,
    parameter int   START_BITS    = 1,
    parameter int   PARITY_BITS   = 0,
    parameter logic PARITY_ODD    = 1'b0,
    parameter int   STOP_BITS     = 1,
    parameter logic LOWBIT_FIRST  = 1'b1
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_enable,
    input  logic [BITS-1:0] in_parallel,
    output logic            out_ready,
    output logic            out_next_word,
    output logic            out_serial
);

    localparam int CLK_DIV  = MAIN_CLK_HZ / SERIAL_CLK_HZ;
    localparam int DW       = $clog2(CLK_DIV);
    localparam int MAX_01   = (START_BITS > BITS) ? START_BITS : BITS;
    localparam int MAX_BITS = (MAX_01 > STOP_BITS) ? MAX_01 : STOP_BITS;
    localparam int CW       = $clog2(MAX_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_BITS - 1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(BITS - 1);
    localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_READY,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   bit_ctr_q, bit_ctr_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            serial_q, serial_d;

    logic            bit_end;
    logic            last_stop;
    logic            latch;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q + DW'(1);
        bit_ctr_d = bit_ctr_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        serial_d  = SERIAL_STOP;

        bit_end   = (div_q == DIV_LAST);
        last_stop = (state_q == ST_STOP) && bit_end && (bit_ctr_q == STOP_LAST);
        // A latch from the final stop cycle chains straight into the next start bit.
        latch     = in_enable && ((state_q == ST_READY) || last_stop);

        case (state_q)
            ST_READY: begin
                div_d = '0;
            end
            ST_START: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_ctr_q == START_LAST) begin
                        bit_ctr_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        bit_ctr_d = bit_ctr_q + CW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    div_d   = '0;
                    shift_d = LOWBIT_FIRST ? (shift_q >> 1) : (shift_q << 1);
                    if (bit_ctr_q == DATA_LAST) begin
                        bit_ctr_d = '0;
                        state_d   = (PARITY_BITS != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_ctr_d = bit_ctr_q + CW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_ctr_q == STOP_LAST) begin
                        bit_ctr_d = '0;
                        state_d   = ST_READY;
                    end else begin
                        bit_ctr_d = bit_ctr_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_READY;
                div_d     = '0;
                bit_ctr_d = '0;
            end
        endcase

        if (latch) begin
            state_d   = ST_START;
            div_d     = '0;
            bit_ctr_d = '0;
            shift_d   = in_parallel;
            parity_d  = (^in_parallel) ^ PARITY_ODD;
        end

        // The line is registered, so it is driven from the level of the upcoming state.
        case (state_d)
            ST_START:  serial_d = SERIAL_START;
            ST_DATA:   serial_d = LOWBIT_FIRST ? shift_d[0] : shift_d[BITS-1];
            ST_PARITY: serial_d = parity_d;
            default:   serial_d = SERIAL_STOP;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_q   <= ST_READY;
            div_q     <= '0;
            bit_ctr_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            serial_q  <= SERIAL_STOP;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_ctr_q <= bit_ctr_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
        end
    end

    assign out_ready     = (state_q == ST_READY);
    assign out_next_word = latch;
    assign out_serial    = serial_q;

endmodule

// File: tb/tb_serial_async_tx.sv
// tb/tb_serial_async_tx.sv - bench for serial_async_tx in three framing configurations
module tb_serial_async_tx;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic [2:0] ser, rdy, nw;

    always #5 clk = ~clk;

    serial_async_tx #(.MAIN_CLK_HZ(16), .SERIAL_CLK_HZ(1)) u0 (
        .in_clk(clk), .in_rst(rst_n), .in_enable(en), .in_parallel(din),
        .out_ready(rdy[0]), .out_next_word(nw[0]), .out_serial(ser[0]));

    serial_async_tx #(.MAIN_CLK_HZ(16), .SERIAL_CLK_HZ(1), .PARITY_BITS(1),
                      .PARITY_ODD(1'b0), .LOWBIT_FIRST(1'b0)) u1 (
        .in_clk(clk), .in_rst(rst_n), .in_enable(en), .in_parallel(din),
        .out_ready(rdy[1]), .out_next_word(nw[1]), .out_serial(ser[1]));

    serial_async_tx #(.MAIN_CLK_HZ(16), .SERIAL_CLK_HZ(1), .PARITY_BITS(1),
                      .PARITY_ODD(1'b1), .LOWBIT_FIRST(1'b0)) u2 (
        .in_clk(clk), .in_rst(rst_n), .in_enable(en), .in_parallel(din),
        .out_ready(rdy[2]), .out_next_word(nw[2]), .out_serial(ser[2]));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame shape per instance: bit k of the frame is start, data, optional parity, stop.
    int cfg_len [3] = '{10, 11, 11};
    bit cfg_par [3] = '{1'b0, 1'b1, 1'b1};
    bit cfg_odd [3] = '{1'b0, 1'b0, 1'b1};
    bit cfg_low [3] = '{1'b1, 1'b0, 1'b0};

    function automatic logic frame_level(input int i, input logic [7:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return cfg_low[i] ? w[k-1] : w[8-k];
        if (cfg_par[i] && k == 9) return (^w) ^ cfg_odd[i];
        return 1'b1;
    endfunction

    int         pos   [3];
    logic [7:0] mword [3];
    bit         model_on = 1'b0;
    int         cyc      = 0;
    int         pcount   = 0;
    int         prev_t   = 0;
    int         last_t   = 0;

    function automatic bit exp_pulse(input int i);
        return en && (pos[i] < 0 || pos[i] == cfg_len[i] * DIV - 1);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_on = 1'b1;
            for (int i = 0; i < 3; i++) pos[i] = -1;
        end else if (model_on) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_pulse(i)) begin
                    pos[i]   = 0;
                    mword[i] = din;
                end else if (pos[i] >= 0) begin
                    pos[i]++;
                    if (pos[i] == cfg_len[i] * DIV) pos[i] = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_serial@%0d", i, cyc), ser[i],
                    (pos[i] >= 0) ? frame_level(i, mword[i], pos[i] / DIV) : 1'b1);
                chk($sformatf("u%0d_ready@%0d", i, cyc), rdy[i], pos[i] < 0);
                chk($sformatf("u%0d_next_word@%0d", i, cyc), nw[i], exp_pulse(i));
            end
        end
        if (nw[0] === 1'b1) begin
            prev_t = last_t;
            last_t = cyc;
            pcount++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [9:0]  a5_line = 10'b1101001010;
    logic [10:0] u1_line = 11'b11111000000;
    logic [10:0] u2_line = 11'b10111000000;

    initial begin
        int p0;
        int waited;
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 8'h00;
        repeat (3) step();
        rst_n = 1'b1;
        chk("reset_serial", ser, 3'b111);
        chk("reset_ready", rdy, 3'b111);
        chk("reset_next_word", nw, 3'b000);

        repeat (100) step();
        chk("idle_serial", ser, 3'b111);
        chk("idle_ready", rdy, 3'b111);

        chk("model_a5_bit1", frame_level(0, 8'hA5, 1), 1'b1);
        chk("model_07_even_parity", frame_level(1, 8'h07, 9), 1'b1);
        chk("model_07_odd_parity", frame_level(2, 8'h07, 9), 1'b0);

        // Single frame 0xA5: pulse, ready drop, ten 16-cycle levels, ready after 160.
        p0  = pcount;
        din = 8'hA5;
        en  = 1'b1;
        step();
        en  = 1'b0;
        chk("a5_pulse_count", pcount - p0, 1);
        chk("a5_ready_low", rdy[0], 1'b0);
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (c % DIV == 0 || c % DIV == DIV - 1)
                chk($sformatf("a5_line_c%0d", c), ser[0], a5_line[c / DIV]);
        end
        step();
        chk("a5_ready_after_160", rdy[0], 1'b1);
        chk("a5_single_pulse", pcount - p0, 1);
        repeat (30) step();

        // Parity and MSB-first order on 0x07.
        din = 8'h07;
        en  = 1'b1;
        step();
        en  = 1'b0;
        for (int c = 0; c < 176; c++) begin
            @(negedge clk);
            if (c % DIV == DIV / 2) begin
                chk($sformatf("p07_even_bit%0d", c / DIV), ser[1], u1_line[c / DIV]);
                chk($sformatf("p07_odd_bit%0d", c / DIV), ser[2], u2_line[c / DIV]);
            end
        end
        repeat (30) step();

        // Back-to-back 0x55 then 0x0F with enable held.
        p0  = pcount;
        din = 8'h55;
        en  = 1'b1;
        step();
        din = 8'h0F;
        waited = 0;
        while (pcount - p0 < 2 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("b2b_second_pulse_seen", pcount - p0, 2);
        step();
        en = 1'b0;
        chk("b2b_pulse_spacing", last_t - prev_t, 160);
        chk("b2b_no_gap_start", ser[0], 1'b0);
        chk("b2b_busy", rdy[0], 1'b0);
        repeat (24) step();
        chk("b2b_0f_bit0", ser[0], 1'b1);
        repeat (200) step();

        // Input changes and enable drop mid-frame must not disturb the latched word.
        din = 8'h3C;
        en  = 1'b1;
        step();
        repeat (40) step();
        din = 8'hC3;
        en  = 1'b0;
        repeat (16) step();
        chk("stable_bit2", ser[0], 1'b1);
        repeat (64) step();
        chk("stable_bit6", ser[0], 1'b0);
        repeat (100) step();
        chk("stable_ready", rdy, 3'b111);

        // Reset during data bit 3 aborts the frame.
        din = 8'h5A;
        en  = 1'b1;
        step();
        en  = 1'b0;
        repeat (70) step();
        rst_n = 1'b0;
        step();
        chk("midreset_serial", ser, 3'b111);
        chk("midreset_ready", rdy, 3'b111);
        rst_n = 1'b1;
        step();
        din = 8'h96;
        en  = 1'b1;
        step();
        en  = 1'b0;
        repeat (200) step();
        chk("post_reset_ready", rdy, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
